// File: rtl/moonpt_dl_ctrl.sv
`default_nettype none
// ============================================================================
// moonpt_dl_ctrl : ioctl ROM-download sequencer and core reset for Moon Patrol
// Rev 1.0
// ============================================================================
module moonpt_dl_ctrl #(
  parameter logic [15:0] R1_BASE  = 16'h4000,
  parameter logic [15:0] R2_BASE  = 16'h6000,
  parameter logic [15:0] R3_BASE  = 16'h7000,
  parameter logic [16:0] TOTAL    = 17'h08000,
  parameter int          HOLD_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rst_req,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [3:0]  rom_we,
  output logic        core_reset,
  output logic        dl_busy,
  output logic        dl_err,
  output logic [7:0]  dl_sum,
  output logic [16:0] dl_count
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [15:0] c_HOLD_LOAD = 16'(HOLD_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_hold, w_hold_nxt;
  logic        r_dl_prev, r_ovf;
  logic        w_dl_rise, w_dl_fall, w_accept, w_in_range, w_set_err;
  logic [3:0]  w_we_dec;
  logic [15:0] w_addr_dec;

  logic [15:0] r_dn_addr;
  logic [7:0]  r_dn_data;
  logic [3:0]  r_rom_we;
  logic        r_core_reset, r_dl_busy, r_dl_err;
  logic [7:0]  r_dl_sum;
  logic [16:0] r_dl_count;

  assign w_dl_rise  = ioctl_download & ~r_dl_prev;
  assign w_dl_fall  = ~ioctl_download & r_dl_prev;
  assign w_accept   = (r_state == S_LOAD) & ioctl_wr & ioctl_download;
  assign w_in_range = (ioctl_addr[24:17] == 8'd0) && (ioctl_addr[16:0] < TOTAL);

  // Region decode; only meaningful when w_in_range is set
  always_comb begin
    w_we_dec   = 4'b1000;
    w_addr_dec = ioctl_addr[15:0] - R3_BASE;
    if (ioctl_addr[16:0] < {1'b0, R1_BASE}) begin
      w_we_dec   = 4'b0001;
      w_addr_dec = ioctl_addr[15:0];
    end else if (ioctl_addr[16:0] < {1'b0, R2_BASE}) begin
      w_we_dec   = 4'b0010;
      w_addr_dec = ioctl_addr[15:0] - R1_BASE;
    end else if (ioctl_addr[16:0] < {1'b0, R3_BASE}) begin
      w_we_dec   = 4'b0100;
      w_addr_dec = ioctl_addr[15:0] - R2_BASE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
      r_hold  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // A download start overrides every state, including an active hold-off
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_set_err   = 1'b0;
    if (w_dl_rise) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_dl_fall) w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_dl_count == TOTAL) && !r_ovf) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = c_HOLD_LOAD;
          end else begin
            w_state_nxt = S_ERROR;
            w_set_err   = 1'b1;
          end
        end
        S_HOLD: begin
          if (rst_req) begin
            w_hold_nxt = c_HOLD_LOAD;
          end else if (r_hold == 16'd0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_hold_nxt = r_hold - 16'd1;
          end
        end
        S_RUN: begin
          if (rst_req) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = c_HOLD_LOAD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_prev    <= 1'b0;
      r_ovf        <= 1'b0;
      r_rom_we     <= 4'd0;
      r_dn_addr    <= 16'd0;
      r_dn_data    <= 8'd0;
      r_core_reset <= 1'b1;
      r_dl_busy    <= 1'b0;
      r_dl_err     <= 1'b0;
      r_dl_sum     <= 8'd0;
      r_dl_count   <= 17'd0;
    end else begin
      r_dl_prev    <= ioctl_download;
      r_rom_we     <= 4'd0;
      r_core_reset <= (w_state_nxt != S_RUN);
      r_dl_busy    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DRAIN);
      if (w_dl_rise) begin
        r_dl_count <= 17'd0;
        r_dl_sum   <= 8'd0;
        r_dl_err   <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_set_err) r_dl_err <= 1'b1;
        if (w_accept) begin
          if (w_in_range) begin
            r_rom_we   <= w_we_dec;
            r_dn_addr  <= w_addr_dec;
            r_dn_data  <= ioctl_dout;
            r_dl_count <= r_dl_count + 17'd1;
            r_dl_sum   <= r_dl_sum + ioctl_dout;
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign rom_we     = r_rom_we;
  assign core_reset = r_core_reset;
  assign dl_busy    = r_dl_busy;
  assign dl_err     = r_dl_err;
  assign dl_sum     = r_dl_sum;
  assign dl_count   = r_dl_count;

endmodule
`default_nettype wire

// File: tb/tb_moonpt_dl_ctrl.sv
`default_nettype none
// ============================================================================
// tb_moonpt_dl_ctrl : self-checking bench for the ROM-download sequencer
// Rev 1.0
// ============================================================================
module tb_moonpt_dl_ctrl;

  localparam logic [15:0] R1  = 16'h4000;
  localparam logic [15:0] R2  = 16'h6000;
  localparam logic [15:0] R3  = 16'h7000;
  localparam int unsigned TOT = 32'h8000;
  localparam int          HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        rst_req = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [3:0]  rom_we;
  logic        core_reset, dl_busy, dl_err;
  logic [7:0]  dl_sum;
  logic [16:0] dl_count;

  always #5 clk_sys = ~clk_sys;

  moonpt_dl_ctrl #(
    .R1_BASE(R1), .R2_BASE(R2), .R3_BASE(R3), .TOTAL(17'(TOT)), .HOLD_CYC(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .rst_req(rst_req), .dn_addr(dn_addr), .dn_data(dn_data), .rom_we(rom_we),
    .core_reset(core_reset), .dl_busy(dl_busy), .dl_err(dl_err),
    .dl_sum(dl_sum), .dl_count(dl_count)
  );

  typedef struct packed {
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [3:0]  we;
    logic [15:0] dn;
    logic [7:0]  dd;
    logic [16:0] cnt;
    logic [7:0]  sum;
  } vec_t;

  vec_t        tbl [13];
  int unsigned c_bnd [5];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state
  logic [3:0]  m_we;
  logic [15:0] m_dn;
  logic [7:0]  m_dd;
  logic [16:0] m_cnt;
  logic [7:0]  m_sum;
  logic        m_ovf;
  int unsigned a;
  int          r, n, mism, strobes;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int region_of(input int unsigned addr);
    if (addr >= TOT) return -1;
    for (int k = 0; k < 4; k++)
      if (addr < c_bnd[k+1]) return k;
    return -1;
  endfunction

  // Apply one byte to the model; returns with m_* reflecting the next cycle
  task automatic model_byte(input logic wr, input int unsigned addr, input logic [7:0] d);
    int rg;
    m_we = 4'd0;
    if (wr) begin
      rg = region_of(addr);
      if (rg >= 0) begin
        m_we  = 4'(1 << rg);
        m_dn  = 16'(addr - c_bnd[rg]);
        m_dd  = d;
        m_cnt = m_cnt + 17'd1;
        m_sum = m_sum + d;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rom_we"}, 64'(rom_we), 64'd0);
    chk({tag, "_dn_addr"}, 64'(dn_addr), 64'd0);
    chk({tag, "_dn_data"}, 64'(dn_data), 64'd0);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_busy_err"}, 64'({dl_busy, dl_err}), 64'd0);
    chk({tag, "_sum_count"}, 64'({dl_sum, dl_count}), 64'd0);
  endtask

  initial begin
    c_bnd[0] = 0; c_bnd[1] = R1; c_bnd[2] = R2; c_bnd[3] = R3; c_bnd[4] = TOT;
    //                wr  addr          data   we       dn        dd     cnt     sum
    tbl[0]  = '{1'b1, 25'h0000000, 8'h11, 4'b0001, 16'h0000, 8'h11, 17'd1, 8'h11};
    tbl[1]  = '{1'b1, 25'h0003FFF, 8'h22, 4'b0001, 16'h3FFF, 8'h22, 17'd2, 8'h33};
    tbl[2]  = '{1'b1, 25'h0004000, 8'h33, 4'b0010, 16'h0000, 8'h33, 17'd3, 8'h66};
    tbl[3]  = '{1'b1, 25'h0005FFF, 8'h44, 4'b0010, 16'h1FFF, 8'h44, 17'd4, 8'hAA};
    tbl[4]  = '{1'b0, 25'h0006000, 8'h55, 4'b0000, 16'h1FFF, 8'h44, 17'd4, 8'hAA};
    tbl[5]  = '{1'b1, 25'h0006000, 8'h66, 4'b0100, 16'h0000, 8'h66, 17'd5, 8'h10};
    tbl[6]  = '{1'b1, 25'h0006FFF, 8'h77, 4'b0100, 16'h0FFF, 8'h77, 17'd6, 8'h87};
    tbl[7]  = '{1'b1, 25'h0007000, 8'h88, 4'b1000, 16'h0000, 8'h88, 17'd7, 8'h0F};
    tbl[8]  = '{1'b1, 25'h0007FFF, 8'h99, 4'b1000, 16'h0FFF, 8'h99, 17'd8, 8'hA8};
    tbl[9]  = '{1'b1, 25'h0008000, 8'hAA, 4'b0000, 16'h0FFF, 8'h99, 17'd8, 8'hA8};
    tbl[10] = '{1'b1, 25'h0010000, 8'hBB, 4'b0000, 16'h0FFF, 8'h99, 17'd8, 8'hA8};
    tbl[11] = '{1'b1, 25'h0200000, 8'hCC, 4'b0000, 16'h0FFF, 8'h99, 17'd8, 8'hA8};
    tbl[12] = '{1'b1, 25'h0000001, 8'h01, 4'b0001, 16'h0001, 8'h01, 17'd9, 8'hA9};

    // Reset values and idle BOOT behaviour
    tick(); tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rst_req = (i % 7) < 3;
      tick();
    end
    rst_req = 1'b0;
    tick();
    chk("boot_core_reset", 64'(core_reset), 64'd1);
    chk("boot_busy_we", 64'({dl_busy, rom_we}), 64'd0);

    // Table session: region boundaries, idle cycle, out-of-range writes
    ioctl_download = 1'b1;
    tick();
    chk("tbl_start_busy", 64'({dl_busy, core_reset}), 64'b11);
    foreach (tbl[i]) begin
      ioctl_wr = tbl[i].wr; ioctl_addr = tbl[i].addr; ioctl_dout = tbl[i].data;
      tick();
      chk($sformatf("tbl%0d_we", i), 64'(rom_we), 64'(tbl[i].we));
      chk($sformatf("tbl%0d_dn", i), 64'({dn_addr, dn_data}), 64'({tbl[i].dn, tbl[i].dd}));
      chk($sformatf("tbl%0d_cnt_sum", i), 64'({dl_count, dl_sum}), 64'({tbl[i].cnt, tbl[i].sum}));
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    chk("tbl_drain_busy", 64'({dl_busy, rom_we}), 64'h10);
    tick();
    chk("tbl_err", 64'({dl_err, core_reset, dl_busy}), 64'b110);
    for (int i = 0; i < 5; i++) begin
      rst_req = 1'b1;
      tick();
    end
    rst_req = 1'b0;
    tick();
    chk("error_sticky", 64'({dl_err, core_reset}), 64'b11);

    // Randomized downloads against the reference model
    m_dn = 16'h0001; m_dd = 8'h01;
    for (int s = 0; s < 4; s++) begin
      m_cnt = 17'd0; m_sum = 8'd0; m_ovf = 1'b0; m_we = 4'd0;
      ioctl_download = 1'b1; rst_req = 1'($urandom_range(0, 1));
      tick();
      chk("rnd_start", 64'({dl_err, dl_count, dl_sum, dl_busy, core_reset}), 64'b11);
      n = 40 + int'($urandom_range(0, 30));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0: a = TOT + $urandom_range(0, 255);
          1: a = 32'h10000 << $urandom_range(0, 8);
          default: a = $urandom_range(0, TOT - 1);
        endcase
        ioctl_wr = ($urandom_range(0, 9) < 7);
        ioctl_addr = 25'(a);
        ioctl_dout = 8'($urandom);
        rst_req = 1'($urandom_range(0, 1));
        model_byte(ioctl_wr, a, ioctl_dout);
        tick();
        chk($sformatf("rnd%0d_cyc%0d", s, i),
            64'({rom_we, dn_addr, dn_data, dl_count, dl_sum, core_reset, dl_busy}),
            64'({m_we, m_dn, m_dd, m_cnt, m_sum, 1'b1, 1'b1}));
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0; rst_req = 1'b0;
      tick(); tick();
      chk("rnd_end_err", 64'({dl_err, core_reset, dl_busy}),
          64'({((m_cnt == 17'(TOT)) && !m_ovf) ? 1'b0 : 1'b1, 1'b1, 1'b0}));
    end

    // Short download 0x0000..0x7FFE
    m_cnt = 17'd0; m_sum = 8'd0; m_ovf = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int unsigned ad = 0; ad < TOT - 1; ad++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(ad); ioctl_dout = ad[7:0];
      model_byte(1'b1, ad, ad[7:0]);
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick(); tick();
    chk("short_err", 64'({dl_err, core_reset}), 64'b11);
    chk("short_count_sum", 64'({dl_count, dl_sum}), 64'({m_cnt, m_sum}));
    for (int i = 0; i < 20; i++) tick();
    chk("short_still_held", 64'({dl_err, core_reset}), 64'b11);

    // Full back-to-back download 0x0000..0x7FFF
    m_cnt = 17'd0; m_sum = 8'd0; m_ovf = 1'b0;
    ioctl_download = 1'b1;
    tick();
    chk("full_start_clears", 64'({dl_err, dl_count}), 64'd0);
    mism = 0; strobes = 0;
    for (int unsigned ad = 0; ad < TOT; ad++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(ad); ioctl_dout = ad[7:0];
      model_byte(1'b1, ad, ad[7:0]);
      tick();
      strobes += int'(rom_we[0]) + int'(rom_we[1]) + int'(rom_we[2]) + int'(rom_we[3]);
      if ({rom_we, dn_addr, dn_data} !== {m_we, m_dn, m_dd}) mism++;
      if (ad == 32'h3FFF) chk("full_3FFF", 64'({rom_we, dn_addr}), 64'({4'b0001, 16'h3FFF}));
      if (ad == 32'h4000) chk("full_4000", 64'({rom_we, dn_addr}), 64'({4'b0010, 16'h0000}));
      if (ad == 32'h7000) chk("full_7000", 64'({rom_we, dn_addr}), 64'({4'b1000, 16'h0000}));
    end
    chk("full_stream_mismatches", 64'(mism), 64'd0);
    chk("full_strobes", 64'(strobes), 64'(TOT));
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    n = 0;
    while (core_reset && n < 100) begin
      tick();
      n++;
      if (n == 1) chk("full_drain_busy", 64'(dl_busy), 64'd1);
    end
    chk("full_release_latency", 64'(n), 64'(2 + HOLD));
    chk("full_count", 64'(dl_count), 64'h08000);
    chk("full_sum_err", 64'({dl_sum, dl_err, dl_busy}), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("run_stays", 64'(core_reset), 64'd0);

    // rst_req for 3 cycles in RUN
    rst_req = 1'b1;
    tick();
    chk("rstreq_assert", 64'(core_reset), 64'd1);
    tick(); tick();
    rst_req = 1'b0;
    n = 0;
    while (core_reset && n < 100) begin
      tick();
      n++;
    end
    chk("rstreq_release_latency", 64'(n), 64'(HOLD));

    // New download aborts RUN immediately
    ioctl_download = 1'b1;
    tick();
    chk("abort_run", 64'({core_reset, dl_busy, dl_count, dl_sum, dl_err}), 64'({2'b11, 26'd0}));
    ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'h5A;
    tick();
    chk("abort_load_strobe", 64'({rom_we, dn_addr, dn_data}), 64'({4'b0001, 16'h0010, 8'h5A}));

    // Asynchronous reset mid-LOAD with a write just presented
    ioctl_addr = 25'h11; ioctl_dout = 8'h5B;
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rst_req = (i < 4);
      tick();
    end
    check_reset_vals("post_rst_boot");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
